// File: rtl/bcd_timer_counter.sv
// BCD up/down timer core: NFIELDS base-60 fields, each a packed ones/tens BCD digit pair.
// Latency: count/tick/done/expired are registered; first step lands CLK_DIV cycles after run rises.
// No backpressure: load/clear are single-cycle strobes, outputs are plain registered levels/pulses.
module bcd_timer_counter #(
  parameter int NFIELDS = 2,
  parameter int CLK_DIV = 50000000,
  parameter int WRAP    = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  input  logic                   mode,
  input  logic                   load,
  input  logic [8*NFIELDS-1:0]   load_val,
  input  logic                   clear,
  output logic [8*NFIELDS-1:0]   count,
  output logic                   tick,
  output logic                   done,
  output logic                   expired
);

  localparam int CW = 8 * NFIELDS;
  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [CW-1:0] TERM_UP   = {NFIELDS{8'h59}};
  localparam logic [CW-1:0] TERM_DOWN = '0;

  // Clamp out-of-range digits so the count only ever holds legal base-60 BCD.
  function automatic logic [CW-1:0] sanitise(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    r = v;
    for (int f = 0; f < NFIELDS; f++) begin
      if (v[8*f +: 4] > 4'd9) r[8*f +: 4] = 4'd9;
      if (v[8*f+4 +: 4] > 4'd5) r[8*f+4 +: 4] = 4'd5;
    end
    return r;
  endfunction

  logic [PW-1:0] presc;
  logic          step_fire;

  logic [CW-1:0] dn_val;
  logic          dn_borrow;
  logic [CW-1:0] up_val;
  logic          up_carry;
  logic [3:0]    dn_ones, dn_tens;
  logic [3:0]    up_ones, up_tens;

  logic [CW-1:0] nxt_val;
  logic          nxt_wrap;
  logic [CW-1:0] term_val;
  logic          at_term;
  logic          nxt_is_term;

  logic [CW-1:0] step_count;
  logic          step_done;
  logic          step_expired;

  // A step fires only on a prescaler rollover that is not pre-empted by clear or load.
  assign step_fire = run && !clear && !load && (presc == PRESC_MAX);

  // Prescaler: restarts on clear/load, frozen while paused, wraps at CLK_DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (clear || load) begin
      presc <= '0;
    end else if (run) begin
      if (presc == PRESC_MAX) presc <= '0;
      else                    presc <= presc + 1'b1;
    end
  end

  // Down-count arithmetic: borrow ripples ones -> tens -> next field; final borrow marks a wrap.
  always_comb begin
    dn_val    = count;
    dn_borrow = 1'b1;
    dn_ones   = 4'd0;
    dn_tens   = 4'd0;
    for (int f = 0; f < NFIELDS; f++) begin
      dn_ones = count[8*f +: 4];
      dn_tens = count[8*f+4 +: 4];
      if (dn_borrow) begin
        if (dn_ones == 4'd0) begin
          dn_ones = 4'd9;
          if (dn_tens == 4'd0) begin
            dn_tens   = 4'd5;
            dn_borrow = 1'b1;
          end else begin
            dn_tens   = dn_tens - 4'd1;
            dn_borrow = 1'b0;
          end
        end else begin
          dn_ones   = dn_ones - 4'd1;
          dn_borrow = 1'b0;
        end
      end
      dn_val[8*f +: 4]   = dn_ones;
      dn_val[8*f+4 +: 4] = dn_tens;
    end
  end

  // Up-count arithmetic: mirror of the down path, 9 -> 0 and 5x -> 0x carry outward.
  always_comb begin
    up_val   = count;
    up_carry = 1'b1;
    up_ones  = 4'd0;
    up_tens  = 4'd0;
    for (int f = 0; f < NFIELDS; f++) begin
      up_ones = count[8*f +: 4];
      up_tens = count[8*f+4 +: 4];
      if (up_carry) begin
        if (up_ones == 4'd9) begin
          up_ones = 4'd0;
          if (up_tens == 4'd5) begin
            up_tens  = 4'd0;
            up_carry = 1'b1;
          end else begin
            up_tens  = up_tens + 4'd1;
            up_carry = 1'b0;
          end
        end else begin
          up_ones  = up_ones + 4'd1;
          up_carry = 1'b0;
        end
      end
      up_val[8*f +: 4]   = up_ones;
      up_val[8*f+4 +: 4] = up_tens;
    end
  end

  // Direction select plus terminal-value detection for the current and next count.
  always_comb begin
    nxt_val     = mode ? dn_val : up_val;
    nxt_wrap    = mode ? dn_borrow : up_carry;
    term_val    = mode ? TERM_DOWN : TERM_UP;
    at_term     = (count == term_val);
    nxt_is_term = (nxt_val == term_val);
  end

  // Step outcome: wrap policy pulses done on the wrap itself; saturate policy parks at terminal.
  always_comb begin
    step_count   = count;
    step_done    = 1'b0;
    step_expired = expired;
    if (WRAP != 0) begin
      step_count   = nxt_val;
      step_done    = nxt_wrap;
      step_expired = 1'b0;
    end else if (at_term) begin
      // Already sitting on terminal: hold; announce once if not yet flagged.
      step_done    = !expired;
      step_expired = 1'b1;
    end else begin
      // Stepping off (or toward) terminal; leaving terminal clears a stale expired.
      step_count   = nxt_val;
      step_done    = nxt_is_term;
      step_expired = nxt_is_term;
    end
  end

  // Count and status registers: clear beats load beats step; tick/done are single-cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      tick    <= 1'b0;
      done    <= 1'b0;
      expired <= 1'b0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      if (clear) begin
        count   <= '0;
        expired <= 1'b0;
      end else if (load) begin
        count   <= sanitise(load_val);
        expired <= 1'b0;
      end else if (step_fire) begin
        count   <= step_count;
        tick    <= 1'b1;
        done    <= step_done;
        expired <= step_expired;
      end
    end
  end

endmodule

// File: tb/tb_bcd_timer_counter.sv
// Directed bench: a saturating (WRAP=0) and a wrapping (WRAP=1) instance share stimulus.
// All checks sample just after the falling edge; inputs change there too.
module tb_bcd_timer_counter;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        mode;
  logic        load;
  logic [15:0] load_val;
  logic        clear;

  logic [15:0] count0, count1;
  logic        tick0, tick1;
  logic        done0, done1;
  logic        expired0, expired1;

  int total = 0;
  int bad   = 0;

  bcd_timer_counter #(.NFIELDS(2), .CLK_DIV(4), .WRAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .run(run), .mode(mode), .load(load),
    .load_val(load_val), .clear(clear), .count(count0), .tick(tick0),
    .done(done0), .expired(expired0)
  );

  bcd_timer_counter #(.NFIELDS(2), .CLK_DIV(4), .WRAP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .run(run), .mode(mode), .load(load),
    .load_val(load_val), .clear(clear), .count(count1), .tick(tick1),
    .done(done1), .expired(expired1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse load for one edge, ending on the following falling edge.
  task automatic do_load(input logic [15:0] v);
    load     = 1'b1;
    load_val = v;
    cyc(1);
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; mode = 1'b0; load = 1'b0; load_val = '0; clear = 1'b0;
    #3;
    chk("rst_count", count0, 16'h0000);
    chk("rst_tick", tick0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_expired", expired0, 1'b0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);

    // Countdown 0003 -> 0000, then saturate (dut0) / wrap (dut1).
    mode = 1'b1; run = 1'b1;
    do_load(16'h0003);
    chk("ld3_count", count0, 16'h0003);
    cyc(3);
    chk("pre_step_tick", tick0, 1'b0);
    chk("pre_step_count", count0, 16'h0003);
    cyc(1);
    chk("c4_count", count0, 16'h0002);
    chk("c4_tick", tick0, 1'b1);
    chk("c4_done", done0, 1'b0);
    cyc(4);
    chk("c8_count", count0, 16'h0001);
    cyc(4);
    chk("c12_count", count0, 16'h0000);
    chk("c12_done", done0, 1'b1);
    chk("c12_expired", expired0, 1'b1);
    cyc(1);
    chk("c13_done", done0, 1'b0);
    chk("c13_tick", tick0, 1'b0);
    cyc(3);
    chk("c16_count", count0, 16'h0000);
    chk("c16_tick", tick0, 1'b1);
    chk("c16_done", done0, 1'b0);
    chk("c16_expired", expired0, 1'b1);
    chk("w_c16_count", count1, 16'h5959);
    chk("w_c16_done", done1, 1'b1);
    chk("w_c16_expired", expired1, 1'b0);

    // Borrow chains across digits and fields.
    do_load(16'h1000);
    chk("ld1000_expired", expired0, 1'b0);
    cyc(4);
    chk("borrow_1000", count0, 16'h0959);
    do_load(16'h0100);
    cyc(4);
    chk("borrow_0100", count0, 16'h0059);

    // Up carry into saturation / wrap.
    mode = 1'b0;
    do_load(16'h5958);
    cyc(4);
    chk("up_5959", count0, 16'h5959);
    chk("up_done", done0, 1'b1);
    chk("up_expired", expired0, 1'b1);
    chk("w_up_5959", count1, 16'h5959);
    cyc(4);
    chk("up_hold", count0, 16'h5959);
    chk("up_hold_tick", tick0, 1'b1);
    chk("up_hold_done", done0, 1'b0);
    chk("w_up_wrap", count1, 16'h0000);
    chk("w_up_wrap_done", done1, 1'b1);
    chk("w_up_wrap_exp", expired1, 1'b0);

    // Reverse direction while expired: step away clears expired.
    mode = 1'b1;
    cyc(4);
    chk("rev_count", count0, 16'h5958);
    chk("rev_expired", expired0, 1'b0);

    // Sanitise and clear-over-load priority.
    run = 1'b0;
    do_load(16'hFA7C);
    chk("sanitise", count0, 16'h5959);
    clear = 1'b1;
    do_load(16'h1234);
    clear = 1'b0;
    chk("clear_prio", count0, 16'h0000);

    // Load landing on a prescaler rollover discards the step.
    do_load(16'h0030);
    run = 1'b1;
    cyc(3);
    do_load(16'h0045);
    chk("ld_roll_tick", tick0, 1'b0);
    chk("ld_roll_count", count0, 16'h0045);
    chk("ld_roll_done", done0, 1'b0);
    cyc(4);
    chk("after_roll", count0, 16'h0044);

    // Pause mid-prescale, then resume the remaining cycles.
    cyc(2);
    run = 1'b0;
    cyc(10);
    chk("pause_count", count0, 16'h0044);
    chk("pause_tick", tick0, 1'b0);
    run = 1'b1;
    cyc(1);
    chk("resume_early", count0, 16'h0044);
    cyc(1);
    chk("resume_step", count0, 16'h0043);
    chk("resume_tick", tick0, 1'b1);

    // Asynchronous reset while saturated.
    do_load(16'h0001);
    cyc(4);
    chk("pre_rst_expired", expired0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_expired", expired0, 1'b0);
    chk("arst_count0", count0, 16'h0000);
    cyc(1);
    rst_n = 1'b1;

    // Asynchronous reset while holding 0421.
    run = 1'b0;
    do_load(16'h0421);
    chk("ld0421", count0, 16'h0421);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", count0, 16'h0000);
    cyc(1);
    mode = 1'b0; run = 1'b1;
    rst_n = 1'b1;
    cyc(3);
    chk("post_rst_hold", count0, 16'h0000);
    chk("post_rst_notick", tick0, 1'b0);
    cyc(1);
    chk("post_rst_step", count0, 16'h0001);
    chk("post_rst_tick", tick0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
